// File: rtl/fifo2axi_unpack.sv
// fifo2axi_unpack
//   Pops 202-bit packed words from a fall-through FIFO and rebuilds 256-bit
//   AXI4-Stream beats. Each packet is one header word (phase 0, carries tuser)
//   followed by data words in phases 1,2,3,4,1,... Four data words carry
//   three beats.
//
// Ports
//   clk, reset     clock; synchronous active-high reset
//   fifo_dout      packed word at FIFO head, valid when !fifo_empty
//   fifo_empty     FIFO empty flag
//   fifo_rd_en     pop FIFO head this cycle (combinational, fall-through FIFO)
//   m_tdata/tstrb/tuser/tlast/tvalid, m_tready   AXIS master
//   proto_err      1-cycle pulse after a word with an unexpected phase is popped
//   pkt_cnt        packets emitted (tlast beats accepted), wraps at 2^32
//
// Only the default parameter values are supported.
module fifo2axi_unpack #(
  parameter int TDATA_BITS = 256,
  parameter int TUSER_BITS = 128,
  parameter int WORD_BITS  = 202
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WORD_BITS-1:0]    fifo_dout,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  output logic [TDATA_BITS-1:0]   m_tdata,
  output logic [TDATA_BITS/8-1:0] m_tstrb,
  output logic [TUSER_BITS-1:0]   m_tuser,
  output logic                    m_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    proto_err,
  output logic [31:0]             pkt_cnt
);

  localparam int PL_BITS   = WORD_BITS - 10;  // 192-bit payload field
  localparam int STRB_BITS = TDATA_BITS / 8;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_DATA = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // Registered state
  state_t                  state_q,     state_d;
  logic [2:0]              exp_q,       exp_d;
  logic [PL_BITS-1:0]      hold_q,      hold_d;
  logic [TUSER_BITS-1:0]   tuser_hdr_q, tuser_hdr_d;
  logic [TDATA_BITS-1:0]   m_tdata_q,   m_tdata_d;
  logic [STRB_BITS-1:0]    m_tstrb_q,   m_tstrb_d;
  logic [TUSER_BITS-1:0]   m_tuser_q,   m_tuser_d;
  logic                    m_tlast_q,   m_tlast_d;
  logic                    m_tvalid_q,  m_tvalid_d;
  logic                    proto_err_q, proto_err_d;
  logic [31:0]             pkt_cnt_q,   pkt_cnt_d;

  // Head-word decode
  logic [PL_BITS-1:0]    word_p;
  logic [4:0]            word_cnt;
  logic [2:0]            word_ph;
  logic                  word_last;
  logic                  unused_bit0;

  logic                  out_free;
  logic                  ph_ok;
  logic                  emits;
  logic                  pop;
  logic [TDATA_BITS-1:0] beat_data;
  logic [STRB_BITS-1:0]  beat_strb;

  assign word_p      = fifo_dout[WORD_BITS-1:10];
  assign word_cnt    = fifo_dout[9:5];
  assign word_ph     = fifo_dout[4:2];
  assign word_last   = fifo_dout[1];
  assign unused_bit0 = fifo_dout[0];

  always_comb begin
    // Output register can take a new beat if empty or being drained now.
    out_free = !m_tvalid_q || m_tready;

    // Phase check and whether the head word completes a beat.
    ph_ok = 1'b0;
    emits = 1'b0;
    case (state_q)
      ST_HDR:  ph_ok = (word_ph == 3'd0);
      ST_DATA: begin
        ph_ok = (word_ph == exp_q);
        // ph1 only fills the holding register unless it ends the packet.
        emits = ph_ok && ((word_ph != 3'd1) || word_last);
      end
      default: ;
    endcase

    // Beat assembly from the current payload and the carried-over bits.
    case (word_ph)
      3'd1:    beat_data = {64'b0, word_p};
      3'd2:    beat_data = {word_p[63:0], hold_q};
      3'd3:    beat_data = {word_p[127:0], hold_q[127:0]};
      3'd4:    beat_data = {word_p, hold_q[63:0]};
      default: beat_data = '0;
    endcase

    if (!word_last || word_cnt == 5'd0)
      beat_strb = '1;
    else
      beat_strb = (STRB_BITS'(1) << word_cnt) - STRB_BITS'(1);

    // Non-emitting words (headers, ph1, errors, drops) never wait on the output.
    pop = !reset && !fifo_empty && (!emits || out_free);

    state_d     = state_q;
    exp_d       = exp_q;
    hold_d      = hold_q;
    tuser_hdr_d = tuser_hdr_q;
    m_tdata_d   = m_tdata_q;
    m_tstrb_d   = m_tstrb_q;
    m_tuser_d   = m_tuser_q;
    m_tlast_d   = m_tlast_q;
    m_tvalid_d  = m_tvalid_q;
    proto_err_d = 1'b0;
    pkt_cnt_d   = pkt_cnt_q;

    if (m_tvalid_q && m_tready) begin
      m_tvalid_d = 1'b0;
      if (m_tlast_q)
        pkt_cnt_d = pkt_cnt_q + 32'd1;
    end

    if (pop) begin
      if (state_q == ST_DROP) begin
        if (word_last)
          state_d = ST_HDR;
      end else if (!ph_ok) begin
        // Wrong phase: discard word, then resync at the next packet boundary.
        proto_err_d = 1'b1;
        state_d     = word_last ? ST_HDR : ST_DROP;
      end else if (state_q == ST_HDR) begin
        tuser_hdr_d = word_p[TUSER_BITS-1:0];
        state_d     = ST_DATA;
        exp_d       = 3'd1;
      end else begin
        case (word_ph)
          3'd1:    hold_d = word_p;
          3'd2:    hold_d = {64'b0, word_p[191:64]};
          3'd3:    hold_d = {128'b0, word_p[191:128]};
          default: hold_d = hold_q;
        endcase
        exp_d = (exp_q == 3'd4) ? 3'd1 : exp_q + 3'd1;
        if (word_last)
          state_d = ST_HDR;
        if (emits) begin
          m_tdata_d  = beat_data;
          m_tstrb_d  = beat_strb;
          m_tuser_d  = tuser_hdr_q;
          m_tlast_d  = word_last;
          m_tvalid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HDR;
      exp_q       <= 3'd1;
      hold_q      <= '0;
      tuser_hdr_q <= '0;
      m_tdata_q   <= '0;
      m_tstrb_q   <= '0;
      m_tuser_q   <= '0;
      m_tlast_q   <= 1'b0;
      m_tvalid_q  <= 1'b0;
      proto_err_q <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      hold_q      <= hold_d;
      tuser_hdr_q <= tuser_hdr_d;
      m_tdata_q   <= m_tdata_d;
      m_tstrb_q   <= m_tstrb_d;
      m_tuser_q   <= m_tuser_d;
      m_tlast_q   <= m_tlast_d;
      m_tvalid_q  <= m_tvalid_d;
      proto_err_q <= proto_err_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign fifo_rd_en = pop;
  assign m_tdata    = m_tdata_q;
  assign m_tstrb    = m_tstrb_q;
  assign m_tuser    = m_tuser_q;
  assign m_tlast    = m_tlast_q;
  assign m_tvalid   = m_tvalid_q;
  assign proto_err  = proto_err_q;
  assign pkt_cnt    = pkt_cnt_q;

endmodule

// File: tb/tb_fifo2axi_unpack.sv
// Scoreboard bench for fifo2axi_unpack: stimulus pushes FIFO words and the
// expected beats; a monitor pops and compares each accepted beat.
module tb_fifo2axi_unpack;

  logic         clk = 1'b0;
  logic         reset;
  logic [201:0] fifo_dout;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [255:0] m_tdata;
  logic [31:0]  m_tstrb;
  logic [127:0] m_tuser;
  logic         m_tlast;
  logic         m_tvalid;
  logic         m_tready;
  logic         proto_err;
  logic [31:0]  pkt_cnt;

  fifo2axi_unpack dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .m_tdata    (m_tdata),
    .m_tstrb    (m_tstrb),
    .m_tuser    (m_tuser),
    .m_tlast    (m_tlast),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .proto_err  (proto_err),
    .pkt_cnt    (pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  strb;
    logic [127:0] user;
    logic         last;
  } beat_t;

  logic [201:0] wq[$];     // FIFO model contents
  beat_t        expq[$];   // expected beats
  int n_cmp  = 0;
  int n_fail = 0;
  int n_beat = 0;
  int n_perr = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else
      $display("ok   %s = %0h", name, act);
  endtask

  function automatic logic [201:0] mk(input logic [191:0] p, input logic [4:0] cnt,
                                      input logic [2:0] ph, input logic last);
    return {p, cnt, ph, last, 1'b0};
  endfunction

  function automatic logic [767:0] make_src(input int seed);
    logic [767:0] s;
    for (int i = 0; i < 24; i++)
      s[32*i +: 32] = (32'(seed) << 16) | 32'(i) | 32'h0A00_0000;
    return s;
  endfunction

  // FIFO model: pop decisions sampled mid-cycle, head updated after the edge.
  initial begin
    logic pop_now;
    fifo_empty = 1'b1;
    fifo_dout  = '0;
    forever begin
      @(negedge clk);
      pop_now = fifo_rd_en;
      @(posedge clk);
      #1;
      if (pop_now && wq.size() > 0)
        void'(wq.pop_front());
      fifo_empty = (wq.size() == 0);
      fifo_dout  = (wq.size() == 0) ? '0 : wq[0];
    end
  end

  // Monitor: beat compare, hold stability, empty-pop and proto_err tracking.
  initial begin
    beat_t cur, prev, e;
    logic  prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      cur = '{data: m_tdata, strb: m_tstrb, user: m_tuser, last: m_tlast};
      if (proto_err) n_perr++;
      if (fifo_empty) begin
        n_cmp++;
        if (fifo_rd_en) begin
          n_fail++;
          $display("FAIL pop_while_empty: fifo_rd_en=1 expected 0");
        end
      end
      if (prev_stall && !reset) begin
        n_cmp++;
        if (!m_tvalid || cur !== prev) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%0b got %0h expected %0h", m_tvalid, cur, prev);
        end
      end
      if (m_tvalid && m_tready && !reset) begin
        n_cmp++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL beat: unexpected beat %0h", cur);
        end else begin
          e = expq.pop_front();
          if (cur !== e) begin
            n_fail++;
            $display("FAIL beat%0d: got %0h expected %0h", n_beat, cur, e);
          end else
            $display("beat%0d ok: data=%0h strb=%0h last=%0b", n_beat, cur.data, cur.strb, cur.last);
          n_beat++;
        end
      end
      prev_stall = m_tvalid && !m_tready && !reset;
      prev = cur;
    end
  end

  // Push a header plus nwords data words; last on the final one.
  // Expected beats are slices of the 768-bit source image.
  task automatic send_pkt(input logic [127:0] tuser, input logic [767:0] s, input int nwords,
                          input logic [4:0] cnt, input logic [31:0] last_strb);
    beat_t b;
    if (nwords == 1) begin
      b = '{data: {64'b0, s[191:0]}, strb: last_strb, user: tuser, last: 1'b1};
      expq.push_back(b);
    end else begin
      for (int k = 0; k < nwords - 1; k++) begin
        b.data = s[256*k +: 256];
        b.user = tuser;
        b.last = (k == nwords - 2);
        b.strb = b.last ? last_strb : 32'hFFFF_FFFF;
        expq.push_back(b);
      end
    end
    wq.push_back(mk({64'b0, tuser}, 5'd0, 3'd0, 1'b0));
    for (int w = 0; w < nwords; w++)
      wq.push_back(mk(s[192*w +: 192], cnt, 3'(w + 1), w == nwords - 1));
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wq.size() == 0 && expq.size() == 0 && !m_tvalid) break;
    end
    if (i == 300) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: pending words=%0d beats=%0d expected 0/0", name, wq.size(), expq.size());
    end
  endtask

  initial begin
    int i;
    reset    = 1'b1;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 256'(m_tvalid), 256'd0);
    chk("rst_tlast", 256'(m_tlast), 256'd0);
    chk("rst_tdata", m_tdata, 256'd0);
    chk("rst_tstrb", 256'(m_tstrb), 256'd0);
    chk("rst_tuser", 256'(m_tuser), 256'd0);
    chk("rst_rd_en", 256'(fifo_rd_en), 256'd0);
    chk("rst_proto_err", 256'(proto_err), 256'd0);
    chk("rst_pkt_cnt", 256'(pkt_cnt), 256'd0);
    @(posedge clk); #2;
    reset = 1'b0;

    // 1) full 3-beat packet, cnt=0 on ph4
    send_pkt({4{32'hA5A5_A5A5}}, make_src(1), 4, 5'd0, 32'hFFFF_FFFF);
    wait_idle("t1");
    chk("t1_pkt_cnt", 256'(pkt_cnt), 256'd1);

    // 2) single-beat packet ending on ph1, cnt=5
    send_pkt(128'h1111_2222_3333_4444_5555_6666_7777_8888, make_src(2), 1, 5'd5, 32'h0000_001F);
    wait_idle("t2");
    chk("t2_pkt_cnt", 256'(pkt_cnt), 256'd2);

    // 3) ends on ph2, cnt=16: one beat B0, upper ph2 payload dropped
    send_pkt(128'hDEAD_BEEF, make_src(3), 2, 5'd16, 32'h0000_FFFF);
    wait_idle("t3");
    chk("t3_pkt_cnt", 256'(pkt_cnt), 256'd3);

    // 4) backpressure: tready low for 10 cycles
    @(posedge clk); #2;
    m_tready = 1'b0;
    send_pkt(128'hCAFE_0004, make_src(4), 4, 5'd31, 32'h7FFF_FFFF);
    repeat (10) @(posedge clk);
    #2;
    chk("t4_words_left", 256'(wq.size()), 256'd2);
    chk("t4_stall_valid", 256'(m_tvalid), 256'd1);
    chk("t4_stall_rd_en", 256'(fifo_rd_en), 256'd0);
    m_tready = 1'b1;
    wait_idle("t4");
    chk("t4_pkt_cnt", 256'(pkt_cnt), 256'd4);

    // 5) phase skip: ph0, ph3, ph4, ph1(last) -> one error, all discarded
    begin
      logic [767:0] s5;
      s5 = make_src(5);
      i = n_perr;
      wq.push_back(mk(192'h55, 5'd0, 3'd0, 1'b0));
      wq.push_back(mk(s5[191:0], 5'd0, 3'd3, 1'b0));
      wq.push_back(mk(s5[383:192], 5'd0, 3'd4, 1'b0));
      wq.push_back(mk(s5[575:384], 5'd0, 3'd1, 1'b1));
      send_pkt(128'hB00B_0006, make_src(6), 3, 5'd1, 32'h0000_0001);
      wait_idle("t5");
      chk("t5_proto_err_pulses", 256'(n_perr - i), 256'd1);
      chk("t5_pkt_cnt", 256'(pkt_cnt), 256'd5);
    end

    // 6) reset while a beat waits in the output register
    @(posedge clk); #2;
    m_tready = 1'b0;
    send_pkt(128'h0BAD, make_src(7), 4, 5'd0, 32'hFFFF_FFFF);
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_tvalid) break;
    end
    chk("t6_valid_before_reset", 256'(m_tvalid), 256'd1);
    @(posedge clk); #2;
    reset = 1'b1;
    wq.delete();
    expq.delete();
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("t6_valid_after_reset", 256'(m_tvalid), 256'd0);
    chk("t6_pkt_cnt_after_reset", 256'(pkt_cnt), 256'd0);
    m_tready = 1'b1;
    send_pkt(128'h6666_0008, make_src(8), 4, 5'd8, 32'h0000_00FF);
    wait_idle("t6");
    chk("t6_pkt_cnt", 256'(pkt_cnt), 256'd1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
